memram_p: RTL

// - Parametrised single-port synchronous data RAM; next generation of the 16x8 processor data memory.
// - Adds generic width/depth, a req/ready handshake, registered read with a valid strobe,
//   and a hardware clear sequencer that zeroes the array after reset or on command.
// - Sits between the processor datapath (load/store) and local storage; one access per cycle.

---
 rtl/memram_p_if.sv | 38 +++
 rtl/memram_p.sv | 124 ++++++++++++
 2 files changed

// File: rtl/memram_p_if.sv
// Access bus between the processor load/store path and memram_p.
// Defining MEMRAM_PARITY_EN adds the rd_perr / perr_inj pair.
interface memram_p_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              clr;
    logic              req;
    logic              wren;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] write_data;
    logic              ready;
    logic              busy;
    logic [DATA_W-1:0] read_data;
    logic              rvalid;
`ifdef MEMRAM_PARITY_EN
    logic              rd_perr;
    logic              perr_inj;

    modport master (
        output clr, req, wren, address, write_data, perr_inj,
        input  ready, busy, read_data, rvalid, rd_perr
    );
    modport slave (
        input  clr, req, wren, address, write_data, perr_inj,
        output ready, busy, read_data, rvalid, rd_perr
    );
`else
    modport master (
        output clr, req, wren, address, write_data,
        input  ready, busy, read_data, rvalid
    );
    modport slave (
        input  clr, req, wren, address, write_data,
        output ready, busy, read_data, rvalid
    );
`endif
endinterface

// File: rtl/memram_p.sv
// Single-port synchronous data RAM with req/ready access, registered read and a clear sequencer.
// Optional per-word even parity is enabled by defining MEMRAM_PARITY_EN.
module memram_p #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic       clk,
    input  logic       rst,
    memram_p_if.slave  bus
);
`ifdef MEMRAM_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int                MEM_W     = DATA_W + PAR_W;
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {S_CLEAR, S_RUN} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] read_data_q, read_data_d;
    logic              rvalid_q, rvalid_d;

    logic [MEM_W-1:0]  mem [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [MEM_W-1:0]  mem_wdata;
    logic [MEM_W-1:0]  wr_word;
    logic [MEM_W-1:0]  rd_word;
    logic              addr_ok;
    logic              ready;

    // Extended by one bit so DEPTH == 2**ADDR_W still compares correctly.
    assign addr_ok = {1'b0, bus.address} < DEPTH_X;
    assign ready   = (state_q == S_RUN) && !bus.clr;
    assign rd_word = addr_ok ? mem[bus.address] : '0;

`ifdef MEMRAM_PARITY_EN
    logic rd_perr_q, rd_perr_d;
    assign wr_word = {(^bus.write_data) ^ bus.perr_inj, bus.write_data};
`else
    assign wr_word = bus.write_data;
`endif

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        read_data_d = read_data_q;
        rvalid_d    = 1'b0;
`ifdef MEMRAM_PARITY_EN
        rd_perr_d   = 1'b0;
`endif
        mem_we      = 1'b0;
        mem_waddr   = bus.address;
        mem_wdata   = wr_word;

        if (state_q == S_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = '0;
            if (cnt_q == LAST_ADDR) begin
                state_d = S_RUN;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + ADDR_W'(1);
            end
        end else if (bus.clr) begin
            state_d = S_CLEAR;
            cnt_d   = '0;
        end else if (bus.req) begin
            if (bus.wren) begin
                mem_we = addr_ok;
            end else begin
                read_data_d = rd_word[DATA_W-1:0];
                rvalid_d    = 1'b1;
`ifdef MEMRAM_PARITY_EN
                // Stored bit makes the word even; any odd word is a mismatch.
                rd_perr_d   = ^rd_word;
`endif
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_CLEAR;
            cnt_q       <= '0;
            read_data_q <= '0;
            rvalid_q    <= 1'b0;
`ifdef MEMRAM_PARITY_EN
            rd_perr_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            read_data_q <= read_data_d;
            rvalid_q    <= rvalid_d;
`ifdef MEMRAM_PARITY_EN
            rd_perr_q   <= rd_perr_d;
`endif
        end
    end

    // NOTE: the array has no reset; the clear sequencer gives it defined contents instead.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.ready     = ready;
    assign bus.busy      = (state_q == S_CLEAR);
    assign bus.read_data = read_data_q;
    assign bus.rvalid    = rvalid_q;
`ifdef MEMRAM_PARITY_EN
    assign bus.rd_perr   = rd_perr_q;
`endif
endmodule
